// File: rtl/uart_rx_if.sv
// uart_rx_if -- groups the serial input, controls and receive results of
// uart_rx into one bundle.
//   RxD        serial line, idle high
//   en         receiver enable
//   mode       stop bits checked: 0 = one, 1 = two
//   Dout[7:0]  last received data byte
//   valid      one-cycle pulse, good frame received
//   frame_err  one-cycle pulse, stop bit read as 0
//   busy       receiver not idle
// slave  : receiver side (uart_rx)
// master : line driver / consumer side
interface uart_rx_if;
    logic       RxD;
    logic       en;
    logic       mode;
    logic [7:0] Dout;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport slave (
        input  RxD, en, mode,
        output Dout, valid, frame_err, busy
    );

    modport master (
        output RxD, en, mode,
        input  Dout, valid, frame_err, busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- oversampling asynchronous serial receiver, 8 data bits, no
// parity, one or two stop bits.
// Ports:
//   clk2x  sole clock, OVERSAMPLE cycles per serial bit
//   rst    asynchronous active-high reset
//   bus    uart_rx_if.slave: RxD/en/mode in, Dout/valid/frame_err/busy out
// Parameters:
//   OVERSAMPLE  clk2x cycles per bit (even, 8..64)
//   MSB_FIRST   0: first data bit lands in Dout[0]; 1: in Dout[7]
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic      clk2x,
    input  logic      rst,
    uart_rx_if.slave  bus
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] C_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        r_state, w_state_n;
    logic          r_sync1, r_sync2, r_rxs_d;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [3:0]    r_idx, w_idx_n;
    logic [7:0]    r_shift, w_shift_n;
    logic [7:0]    r_dout, w_dout_n;
    logic          r_mode, w_mode_n;
    logic          r_valid, w_valid_n;
    logic          r_ferr, w_ferr_n;

    logic          w_rxs;
    logic          w_fall;
    logic          w_mid;
    logic [CW-1:0] w_cnt_inc;
    logic [7:0]    w_shift_in;

    assign w_rxs     = r_sync2;
    // r_rxs_d tracks rxs in every state, so a start edge landing on the
    // first IDLE cycle after a frame is still seen.
    assign w_fall    = r_rxs_d & ~w_rxs;
    assign w_mid     = (r_cnt == C_LAST);
    assign w_cnt_inc = w_mid ? '0 : r_cnt + CW'(1);
    assign w_shift_in = MSB_FIRST ? {r_shift[6:0], w_rxs}
                                  : {w_rxs, r_shift[7:1]};

    // Synchronizer and edge-detect history, reset to the idle line level.
    always_ff @(posedge clk2x or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync1 <= bus.RxD;
            r_sync2 <= r_sync1;
            r_rxs_d <= r_sync2;
        end
    end

    always_ff @(posedge clk2x or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_dout  <= '0;
            r_mode  <= 1'b0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_shift <= w_shift_n;
            r_dout  <= w_dout_n;
            r_mode  <= w_mode_n;
            r_valid <= w_valid_n;
            r_ferr  <= w_ferr_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_idx_n   = r_idx;
        w_shift_n = r_shift;
        w_dout_n  = r_dout;
        w_mode_n  = r_mode;
        w_valid_n = 1'b0;
        w_ferr_n  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                w_idx_n = '0;
                if (bus.en && w_fall) begin
                    w_state_n = S_START;
                    w_mode_n  = bus.mode;
                end
            end

            S_START: begin
                if (r_cnt == C_HALF) begin
                    w_cnt_n = '0;
                    w_idx_n = '0;
                    // Line back high at mid start bit: glitch, drop it.
                    w_state_n = w_rxs ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end

            S_DATA: begin
                w_cnt_n = w_cnt_inc;
                if (w_mid) begin
                    w_shift_n = w_shift_in;
                    w_idx_n   = r_idx + 4'd1;
                    if (r_idx == 4'd7) begin
                        w_state_n = S_STOP;
                    end
                end
            end

            S_STOP: begin
                // Index enters at 8; in two-stop mode it drops to 0 after
                // the first good stop sample to mark the second one.
                w_cnt_n = w_cnt_inc;
                if (w_mid) begin
                    if (!w_rxs) begin
                        w_dout_n  = r_shift;
                        w_ferr_n  = 1'b1;
                        w_state_n = S_BREAK;
                    end else if (r_mode && r_idx == 4'd8) begin
                        w_idx_n = '0;
                    end else begin
                        w_dout_n  = r_shift;
                        w_valid_n = 1'b1;
                        w_state_n = S_IDLE;
                    end
                end
            end

            S_BREAK: begin
                w_cnt_n = '0;
                w_idx_n = '0;
                if (w_rxs) begin
                    w_state_n = S_IDLE;
                end
            end

            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    assign bus.Dout      = r_dout;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_ferr;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, clk2x cycles per serial bit; even, 8..64.
REQ-002 Parameter MSB_FIRST, default 0; 0 = first data bit received goes to Dout[0], 1 = first data bit goes to Dout[7].
REQ-003 clk2x  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 RxD  input  1  serial line, idle high, asynchronous to clk2x.
REQ-006 en  input  1  receiver enable, sampled only in IDLE.
REQ-007 mode  input  1  stop bits checked: 0 = one, 1 = two; sampled at start-bit detection and held for the frame.
REQ-008 Dout  output  8  last received data byte.
REQ-009 valid  output  1  one-cycle pulse, good frame received.
REQ-010 frame_err  output  1  one-cycle pulse, stop bit read as 0.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 RxD passes a 2-flop synchronizer (flops reset to 1); all logic below uses the synchronized value rxs.
REQ-013 States: IDLE, START, DATA, STOP, BREAK; one bit counter (0..OVERSAMPLE-1) and one bit index (0..8) shared by all states.
REQ-014 IDLE -> START when en=1 and rxs falls from 1 to 0 between consecutive cycles; bit counter cleared.
REQ-015 START: sample rxs when bit counter reaches OVERSAMPLE/2-1; rxs=1 -> IDLE (false start, no pulse); rxs=0 -> DATA, bit counter cleared, bit index 0.
REQ-016 DATA: sample rxs each time bit counter reaches OVERSAMPLE-1 (i.e. mid-bit); shift the sample into the data register per MSB_FIRST; after the 8th sample -> STOP.
REQ-017 STOP: sample at mid-bit as in DATA; mode=1 requires two consecutive stop samples, one bit period apart.
REQ-018 All stop samples 1 -> Dout loaded, valid=1 for exactly one cycle, next state IDLE.
REQ-019 Any stop sample 0 -> Dout loaded with the received byte, frame_err=1 for one cycle, valid stays 0, next state BREAK.
REQ-020 BREAK: remain until rxs=1; then IDLE. No start detection while in BREAK.
REQ-021 The valid or frame_err pulse is asserted on the cycle after the final stop sample; valid and frame_err are never high together.
REQ-022 Back-to-back frames: a start edge arriving in the first cycle of IDLE after a valid pulse is detected.
REQ-023 Dout holds its value between frames; no handshake and no overrun detection; the consumer must take Dout within one frame time.
REQ-024 en deasserted mid-frame has no effect; the frame completes.
REQ-025 Bit counter wraps OVERSAMPLE-1 -> 0 with no extra cycle; total frame time from the rxs falling edge to the pulse = OVERSAMPLE/2 + 8*OVERSAMPLE + (1+mode)*OVERSAMPLE cycles, +-1.

Reset
REQ-026 rst=1 forces immediately, regardless of clock: state IDLE, counters 0, synchronizer 1, Dout=8'h00, valid=0, frame_err=0, busy=0.
REQ-027 Reset asserted mid-frame discards the partial byte; no pulse is emitted on release.
REQ-028 After release, the first frame is received only if its start edge occurs at least 2 clk2x cycles after release.

Verification
REQ-029 Defaults; send 0xA5 (LSB first, 1 stop, 16 cycles per bit) -> valid pulse once, Dout=8'hA5, frame_err=0, busy low after the pulse.
REQ-030 RxD low for 4 cycles, then high -> busy pulses, returns to IDLE, no valid or frame_err pulse, Dout unchanged.
REQ-031 Send 0x3C with stop=0, hold RxD low for 40 bit times, then high -> one frame_err pulse, Dout=8'h3C, no valid; busy until RxD high; next frame 0x81 -> valid, Dout=8'h81.
REQ-032 Back-to-back 0x00 then 0xFF with no idle gap, mode=1 with two stop bits -> two valid pulses, Dout 8'h00 then 8'hFF.
REQ-033 rst pulsed during data bit 3 of 0x5A -> Dout=8'h00, no pulse; following frame 0xC3 -> valid, Dout=8'hC3.
REQ-034 en=0 with frame 0x77 sent -> busy stays 0, no pulse; MSB_FIRST=1 with frame bits 1,0,0,0,0,0,0,0 -> Dout=8'h80.
